fft_sample_streamer: RTL and testbench

//  Sweeps the 1024x16 single-port sample pROM (1-cycle registered read) that

---
 rtl/fft_sample_streamer.sv | 152 +++++++++++++++
 tb/tb_fft_sample_streamer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_streamer.sv
`default_nettype none
// fft_sample_streamer: sweeps a 1-cycle-latency sample ROM and streams it as signed valid/ready frames.
// Revision 1.0
module fft_sample_streamer #(
  parameter int ADDR_W    = 10,
  parameter int FRAME_LEN = 1024,
  parameter int SMP_W     = 12,
  parameter int OUT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  input  logic [15:0]       rom_dout,
  output logic [OUT_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        addr, addr_nxt;
  logic                     inflight, inflight_last;
  logic [1:0]               fifo_cnt;
  logic [1:0]               occupancy;
  logic [OUT_W-1:0]         head_data, tail_data;
  logic                     head_last, tail_last;
  logic                     pop, issue, last_issue;
  logic signed [SMP_W-1:0]  smp_signed;
  logic [OUT_W-1:0]         smp_ext;

  // Offset-binary to two's complement is just an MSB flip, then sign-extend.
  assign smp_signed = {~rom_dout[SMP_W-1], rom_dout[SMP_W-2:0]};
  assign smp_ext    = OUT_W'(smp_signed);

  if (SMP_W < 16) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^rom_dout[15:SMP_W];
  end

  assign m_tvalid   = (fifo_cnt != 2'd0);
  assign pop        = m_tvalid && m_tready;
  assign occupancy  = fifo_cnt + {1'b0, inflight};
  // A read may be issued into the slot freed by a same-cycle pop.
  assign issue      = (state == RUN) &&
                      ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
  assign last_issue = issue && (addr == LAST_ADDR);

  assign rom_ce  = issue;
  assign rom_ad  = addr;
  assign m_tdata = head_data;
  assign m_tlast = m_tvalid && head_last;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (issue) begin
          if (addr == LAST_ADDR) begin
            addr_nxt = '0;
            if (!continuous) state_nxt = DRAIN;
          end else begin
            addr_nxt = addr + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (pop && head_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rom_oce       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      inflight      <= issue;
      inflight_last <= last_issue;
      rom_oce       <= 1'b1;
      frame_done    <= pop && head_last;
    end
  end

  // Two-entry FIFO; an in-flight read always lands here the cycle after issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_cnt  <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            head_data <= smp_ext;
            head_last <= inflight_last;
          end else begin
            tail_data <= smp_ext;
            tail_last <= inflight_last;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head_data <= smp_ext;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= smp_ext;
            tail_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_streamer.sv
`default_nettype none
// tb_fft_sample_streamer: ROM model plus read-order scoreboard for fft_sample_streamer.
// Revision 1.0
module tb_fft_sample_streamer;

  localparam int FL   = 1024;
  localparam int FL16 = 16;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0, m_tready = 1'b0;
  logic [9:0]  rom_ad;
  logic        rom_ce, rom_oce;
  logic [15:0] rom_dout;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tlast, busy, frame_done;

  logic        start16 = 1'b0;
  logic [9:0]  rom_ad16;
  logic        rom_ce16, rom_oce16;
  logic [15:0] rom_dout16, m_tdata16;
  logic        m_tvalid16, m_tlast16, busy16, frame_done16;

  logic [15:0] rom [FL];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fft_sample_streamer dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_dout(rom_dout),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .frame_done(frame_done)
  );

  fft_sample_streamer #(.FRAME_LEN(FL16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .continuous(1'b0),
    .rom_ad(rom_ad16), .rom_ce(rom_ce16), .rom_oce(rom_oce16), .rom_dout(rom_dout16),
    .m_tdata(m_tdata16), .m_tvalid(m_tvalid16), .m_tready(1'b1), .m_tlast(m_tlast16),
    .busy(busy16), .frame_done(frame_done16)
  );

  always @(posedge clk) begin
    if (rom_ce)   rom_dout   <= rom[rom_ad];
    if (rom_ce16) rom_dout16 <= rom[rom_ad16];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [15:0] raw);
    int v;
    v = int'(raw[11:0]) - 2048;
    return v[15:0];
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed {logic [15:0] d; logic last;} exp_t;
  exp_t q[$];
  int   exp_ad = 0, occ = 0, beats = 0, frames = 0, bubbles = 0;
  int   tlast_at[$];
  logic fd_exp = 1'b0, hold = 1'b0, in_frame = 1'b0, hs;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_ad = 0; occ = 0; fd_exp = 1'b0; hold = 1'b0; in_frame = 1'b0;
    end else begin
      hs = m_tvalid && m_tready;
      check("frame_done", frame_done, fd_exp);
      if (frame_done) frames++;
      if (hold) check("valid_hold", m_tvalid, 1);
      if (m_tvalid) begin
        if (q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          check("tdata", m_tdata, q[0].d);
          check("tlast", m_tlast, q[0].last);
        end
      end
      if (busy && m_tready && !m_tvalid && in_frame) bubbles++;
      fd_exp = hs && m_tlast;
      hold   = m_tvalid && !m_tready;
      if (hs) begin
        if (m_tlast) tlast_at.push_back(beats);
        beats++;
        in_frame = 1'b1;
        if (q.size() > 0) void'(q.pop_front());
        occ--;
      end
      if (!busy) in_frame = 1'b0;
      if (rom_ce) begin
        check("rom_ad", rom_ad, exp_ad);
        check("ce_room", occ < 2, 1);
        q.push_back(exp_t'({conv(rom[exp_ad]), exp_ad == FL - 1}));
        occ++;
        exp_ad = (exp_ad == FL - 1) ? 0 : exp_ad + 1;
      end
    end
  end

  int beats16 = 0;
  int tl16[$];
  always @(negedge clk) begin
    if (!reset) begin
      if (rom_ce16) check("ad16_range", rom_ad16 <= 10'd15, 1);
      if (m_tvalid16) begin
        check("tdata16", m_tdata16, conv(rom[beats16 % FL16]));
        if (m_tlast16) tl16.push_back(beats16);
        beats16++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!frame_done && n < max) begin @(posedge clk); #1; n++; end
    if (!frame_done) check("timeout_done", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int target, input int max);
    int n = 0;
    while (beats < target && n < max) begin @(posedge clk); #1; n++; end
    if (beats < target) check("timeout_beats", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, f0, u0, t0, idle_cnt, n;
    rom[0] = 16'h0800; rom[1] = 16'h0D72; rom[2] = 16'h0E03;
    rom[3] = 16'h0FFB; rom[4] = 16'hA005;
    for (int i = 5; i < FL; i++) rom[i] = 16'($urandom);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oce", rom_oce, 0);   check("rst_ce", rom_ce, 0);
    check("rst_ad", rom_ad, 0);     check("rst_valid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0); check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0); check("rst_tlast", m_tlast, 0);
    @(posedge clk); #1 reset = 1'b0; m_tready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("oce_after_rst", rom_oce, 1);

    // 1: basic frame, latency, contiguous beats
    b0 = beats; f0 = frames; u0 = bubbles; t0 = tlast_at.size();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("t1_ce_k1", rom_ce, 1); check("t1_ad_k1", rom_ad, 0);
    check("t1_busy_k1", busy, 1); check("t1_valid_k1", m_tvalid, 0);
    @(negedge clk); check("t1_valid_k2", m_tvalid, 0);
    @(negedge clk); check("t1_valid_k3", m_tvalid, 1); check("t1_beat0", m_tdata, 16'h0000);
    @(negedge clk); check("t1_beat1", m_tdata, 16'h0572);
    @(negedge clk); check("t1_beat2", m_tdata, 16'h0603);
    @(negedge clk); check("t1_beat3", m_tdata, 16'h07FB);
    @(negedge clk); check("t1_beat4", m_tdata, 16'hF805);
    wait_done(3000);
    check("t1_busy_after", busy, 0);
    check("t1_beats", beats - b0, FL);
    check("t1_frames", frames - f0, 1);
    check("t1_bubbles", bubbles - u0, 0);
    check("t1_ntlast", tlast_at.size() - t0, 1);
    if (tlast_at.size() > t0) check("t1_tlast_idx", tlast_at[t0] - b0, FL - 1);

    // 2: stall then random back-pressure
    b0 = beats; f0 = frames; t0 = tlast_at.size();
    pulse_start();
    wait_beats(b0 + 200, 2000);
    @(posedge clk); #1 m_tready = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_ce_stall", rom_ce, 0); check("t2_valid_stall", m_tvalid, 1);
    repeat (7) @(posedge clk);
    n = 0;
    while (!frame_done && n < 20000) begin
      @(posedge clk); #1 m_tready = 1'($urandom_range(0, 1)); n++;
    end
    if (!frame_done) check("t2_timeout", 0, 1);
    m_tready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("t2_beats", beats - b0, FL);
    check("t2_frames", frames - f0, 1);
    if (tlast_at.size() > t0) check("t2_tlast_idx", tlast_at[t0] - b0, FL - 1);
    else check("t2_ntlast", 0, 1);

    // 3: continuous mode
    b0 = beats; f0 = frames; u0 = bubbles; t0 = tlast_at.size();
    continuous = 1'b1;
    pulse_start();
    idle_cnt = 0; n = 0;
    while (frames - f0 < 2 && n < 5000) begin
      @(posedge clk); #1; if (!busy) idle_cnt++; n++;
    end
    continuous = 1'b0;
    wait_done(3000);
    check("t3_idle", idle_cnt, 0);
    check("t3_frames", frames - f0, 3);
    check("t3_beats", beats - b0, 3 * FL);
    check("t3_bubbles", bubbles - u0, 0);
    check("t3_ntlast", tlast_at.size() - t0, 3);
    if (tlast_at.size() >= t0 + 2) begin
      check("t3_tlast0", tlast_at[t0] - b0, FL - 1);
      check("t3_tlast1", tlast_at[t0 + 1] - b0, 2 * FL - 1);
    end

    // 4: async reset mid-frame
    pulse_start();
    wait_beats(beats + 500, 2000);
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check("t4_ce", rom_ce, 0);   check("t4_ad", rom_ad, 0);
    check("t4_valid", m_tvalid, 0); check("t4_tdata", m_tdata, 0);
    check("t4_tlast", m_tlast, 0);  check("t4_busy", busy, 0);
    check("t4_fd", frame_done, 0);  check("t4_oce", rom_oce, 0);
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    b0 = beats;
    pulse_start();
    n = 0;
    while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
    check("t4_restart_valid", m_tvalid, 1);
    check("t4_restart_beat0", m_tdata, 16'h0000);
    wait_done(3000);
    check("t4_beats", beats - b0, FL);

    // 5: start while busy, including on the tlast handshake
    b0 = beats; f0 = frames;
    pulse_start();
    repeat (5) @(posedge clk);
    pulse_start();
    n = 0;
    while (!(m_tvalid && m_tlast) && n < 3000) begin @(posedge clk); #1; n++; end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk); #1;
    check("t5_frames", frames - f0, 1);
    check("t5_beats", beats - b0, FL);
    check("t5_busy", busy, 0);
    check("t5_valid", m_tvalid, 0);

    // 6: short frame build
    @(posedge clk); #1 start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    n = 0;
    while (!frame_done16 && n < 200) begin @(posedge clk); #1; n++; end
    check("t6_done", frame_done16, 1);
    @(posedge clk); #1;
    check("t6_beats", beats16, FL16);
    check("t6_ntlast", tl16.size(), 1);
    if (tl16.size() > 0) check("t6_tlast_idx", tl16[0], FL16 - 1);
    check("t6_busy", busy16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
